// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection for the 5-stage MIPS pipeline.
module id_ex_stage #(
   parameter  int unsigned DW  = 32,
   parameter  int unsigned RW  = 5,
   localparam int unsigned SHW = 5,
   localparam int unsigned CW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hold,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [RW-1:0]   id_rs,
   input  logic [RW-1:0]   id_rt,
   input  logic [RW-1:0]   id_rd,
   input  logic            id_uses_rs,
   input  logic            id_uses_rt,
   input  logic [DW-1:0]   id_rs_data,
   input  logic [DW-1:0]   id_rt_data,
   input  logic [DW-1:0]   id_imm,
   input  logic [SHW-1:0]  id_shamt,
   input  logic [CW-1:0]   id_alu_ctrl,
   input  logic            id_alusrc,
   input  logic            id_shift_src,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            id_memwrite,
   input  logic            id_memtoreg,
   input  logic            exm_regwrite,
   input  logic [RW-1:0]   exm_rd,
   input  logic [DW-1:0]   exm_result,
   input  logic            mwb_regwrite,
   input  logic [RW-1:0]   mwb_rd,
   input  logic [DW-1:0]   mwb_data,
   output logic            stall_id,
   output logic [DW-1:0]   alu_a,
   output logic [DW-1:0]   alu_b,
   output logic [CW-1:0]   alu_ctrl,
   output logic            ex_valid,
   output logic            ex_regwrite,
   output logic            ex_memread,
   output logic            ex_memwrite,
   output logic            ex_memtoreg,
   output logic [RW-1:0]   ex_rd,
   output logic [DW-1:0]   ex_store_data
);

   // Everything the stage holds for the instruction currently in EX.
   typedef struct packed {
      logic            valid;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
      logic            memtoreg;
      logic [RW-1:0]   rd;
      logic [RW-1:0]   rs;
      logic [RW-1:0]   rt;
      logic            uses_rs;
      logic            uses_rt;
      logic [DW-1:0]   rs_data;
      logic [DW-1:0]   rt_data;
      logic [DW-1:0]   imm;
      logic [SHW-1:0]  shamt;
      logic [CW-1:0]   alu_ctrl;
      logic            alusrc;
      logic            shift_src;
   } ex_fields_t;

   ex_fields_t    r_ex;
   ex_fields_t    w_id_fields;
   logic          w_hazard;
   logic [DW-1:0] w_fwd_rs;
   logic [DW-1:0] w_fwd_rt;

   // Bundle the decoded ID fields into the stage payload.
   always_comb begin
      w_id_fields           = '0;
      w_id_fields.valid     = id_valid;
      w_id_fields.regwrite  = id_regwrite;
      w_id_fields.memread   = id_memread;
      w_id_fields.memwrite  = id_memwrite;
      w_id_fields.memtoreg  = id_memtoreg;
      w_id_fields.rd        = id_rd;
      w_id_fields.rs        = id_rs;
      w_id_fields.rt        = id_rt;
      w_id_fields.uses_rs   = id_uses_rs;
      w_id_fields.uses_rt   = id_uses_rt;
      w_id_fields.rs_data   = id_rs_data;
      w_id_fields.rt_data   = id_rt_data;
      w_id_fields.imm       = id_imm;
      w_id_fields.shamt     = id_shamt;
      w_id_fields.alu_ctrl  = id_alu_ctrl;
      w_id_fields.alusrc    = id_alusrc;
      w_id_fields.shift_src = id_shift_src;
   end

   // Load in EX whose result is needed by the instruction in ID.
   always_comb begin
      w_hazard = 1'b0;
      if (r_ex.valid && r_ex.memread && (r_ex.rd != '0) && id_valid) begin
         w_hazard = (id_uses_rs && (id_rs == r_ex.rd)) ||
                    (id_uses_rt && (id_rt == r_ex.rd));
      end
   end

   // Stage register: reset, then freeze, then bubble, then capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ex <= '0;
      end else if (!hold) begin
         if (flush || w_hazard || !id_valid) begin
            r_ex <= '0;
         end else begin
            r_ex <= w_id_fields;
         end
      end
   end

   // rs operand select: youngest producer wins, $0 never forwarded.
   always_comb begin
      w_fwd_rs = r_ex.rs_data;
      if (r_ex.uses_rs) begin
         if (exm_regwrite && (exm_rd != '0) && (exm_rd == r_ex.rs)) begin
            w_fwd_rs = exm_result;
         end else if (mwb_regwrite && (mwb_rd != '0) && (mwb_rd == r_ex.rs)) begin
            w_fwd_rs = mwb_data;
         end
      end
   end

   // rt operand select, same rules as rs.
   always_comb begin
      w_fwd_rt = r_ex.rt_data;
      if (r_ex.uses_rt) begin
         if (exm_regwrite && (exm_rd != '0) && (exm_rd == r_ex.rt)) begin
            w_fwd_rt = exm_result;
         end else if (mwb_regwrite && (mwb_rd != '0) && (mwb_rd == r_ex.rt)) begin
            w_fwd_rt = mwb_data;
         end
      end
   end

   assign stall_id      = w_hazard && !flush;
   assign alu_a         = r_ex.shift_src ? DW'(r_ex.shamt) : w_fwd_rs;
   assign alu_b         = r_ex.alusrc ? r_ex.imm : w_fwd_rt;
   assign ex_store_data = w_fwd_rt;
   assign alu_ctrl      = r_ex.alu_ctrl;
   assign ex_valid      = r_ex.valid;
   assign ex_regwrite   = r_ex.regwrite;
   assign ex_memread    = r_ex.memread;
   assign ex_memwrite   = r_ex.memwrite;
   assign ex_memtoreg   = r_ex.memtoreg;
   assign ex_rd         = r_ex.rd;

endmodule
